// File: rtl/ioport_reader_pkg.sv
// Shared constants for the port input block: register map, idle pin level and
// synchroniser depth bounds.
package ioport_reader_pkg;

  typedef enum logic [1:0] {
    ADDR_PIN  = 2'd0,
    ADDR_FLAG = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_POL  = 2'd3
  } reg_addr_e;

  localparam logic [7:0] PIN_IDLE        = 8'hFF;
  localparam int         SYNC_STAGES_MIN = 2;
  localparam int         SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/ioport_reader_pin_sync.sv
// One port bit: flop-chain synchroniser, optional 3-sample agreement filter
// (IOPORT_READER_GLITCH_FILTER_EN), previous-value flop and edge outputs.
module pin_sync
  import ioport_reader_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pin,
  output logic value,
  output logic rise,
  output logic fall
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_depth
    $error("pin_sync: SYNC_STAGES out of range");
  end

  logic [SYNC_STAGES-1:0] chain;
  logic                   sync;
  logic                   level;
  logic                   prev;

  // Every stage resets high so a released reset with idle-high pins sees no edge.
  // NOTE: sequential state uses non-blocking (<=) so all flops sample together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) chain <= '1;
    else          chain <= {chain[SYNC_STAGES-2:0], pin};
  end

  assign sync = chain[SYNC_STAGES-1];

`ifdef IOPORT_READER_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       filt_q;

  // Current sample plus two held samples must agree before the level moves.
  assign level = (sync == hist[0] && sync == hist[1]) ? sync : filt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist   <= 2'b11;
      filt_q <= 1'b1;
    end else begin
      hist   <= {hist[0], sync};
      filt_q <= level;
    end
  end
`else
  assign level = sync;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) prev <= 1'b1;
    else          prev <= level;
  end

  assign value = level;
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/ioport_reader.sv
// Port input block: pin read-back, edge-triggered interrupt flags with mask and
// polarity, active-low interrupt. Optional filter: IOPORT_READER_GLITCH_FILTER_EN.
module ioport_reader
  import ioport_reader_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] pins,
  input  logic [7:0] data_ddr,
  input  logic [7:0] data_port,
  input  logic [1:0] addr,
  input  logic       re,
  input  logic       we,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       irq_n
);

  logic [7:0] sync_val, rise, fall;
  logic [7:0] flag, mask, pol;
  logic [7:0] hit, clr, flag_next, mask_next, pol_next;
  logic [7:0] pin_value, rd_value;
  reg_addr_e  sel;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clock  (clock),
      .reset_n(reset_n),
      .pin    (pins[i]),
      .value  (sync_val[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  assign sel = reg_addr_e'(addr);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hit       = ~data_ddr & ((pol & rise) | (~pol & fall));
    pin_value = (data_ddr & data_port) | (~data_ddr & sync_val);

    clr = '0;
    if (we && sel == ADDR_FLAG) clr = clr | data_in;
    if (re && sel == ADDR_FLAG) clr = clr | flag;
    // Set is OR-ed in last so a same-cycle edge survives any clear.
    flag_next = (flag & ~clr) | hit;

    mask_next = (we && sel == ADDR_MASK) ? data_in : mask;
    pol_next  = (we && sel == ADDR_POL)  ? data_in : pol;

    rd_value = '0;
    case (sel)
      ADDR_PIN:  rd_value = pin_value;
      ADDR_FLAG: rd_value = flag;
      ADDR_MASK: rd_value = mask;
      ADDR_POL:  rd_value = pol;
      default:   rd_value = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flag     <= '0;
      mask     <= '0;
      pol      <= '0;
      data_out <= '0;
      irq_n    <= 1'b1;
    end else begin
      flag  <= flag_next;
      mask  <= mask_next;
      pol   <= pol_next;
      if (re) data_out <= rd_value;
      // Built from next-state values so clears and mask writes act at their own edge.
      irq_n <= ~|(flag_next & mask_next);
    end
  end

endmodule

// File: doc/ioport_reader.md
# ioport_reader

Input-direction companion to the DDR/port-latch output block. It synchronises the eight external port pins into the clock domain and returns the port read value, where DDR=1 bits read back the output latch and DDR=0 bits read the synchronised pin. It also detects programmable edges on input bits and latches them into interrupt flags with a maskable active-low interrupt. It sits beside the output block and shares `data_ddr`/`data_port` with it; the bus decoder drives `addr`/`re`/`we`.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth, legal range 2..4.

Ports:
- `clock` in 1: system clock; all state is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `pins` in 8: external port pins, asynchronous to `clock`.
- `data_ddr` in 8: direction bits, 1 = output.
- `data_port` in 8: output latch value.
- `addr` in 2: register select. 0 = PIN, 1 = FLAG, 2 = MASK, 3 = POL.
- `re` in 1: read strobe, one cycle.
- `we` in 1: write strobe, one cycle.
- `data_in` in 8: write data.
- `data_out` out 8: registered read data.
- `irq_n` out 1: registered interrupt, active low.

## Operation
- **Synchroniser:** each pin passes through a `SYNC_STAGES` flop chain to produce `sync[7:0]`. `prev` is `sync` delayed by one cycle.
- **Edge detection:**
  - `rise = sync & ~prev`; `fall = ~sync & prev`.
  - `hit[i] = ~data_ddr[i] & (pol[i] ? rise[i] : fall[i])`.
  - POL=1 selects rising edge, POL=0 selects falling edge.
- **FLAG register:** next value is `(flag & ~clr) | hit`.
  - `clr` is `data_in` on a write to FLAG (write-1-to-clear).
  - `clr` is the flag value returned on a read of FLAG (read-to-clear).
  - When set and clear hit the same bit in the same cycle, set wins, so no event is lost.
- **MASK and POL:** plain registers, written from `data_in` when `we` is high and the address matches. A write to PIN is ignored.
- **Reads:** on `re`, `data_out` loads the selected value. When `re` is low, `data_out` holds its value.
  - PIN returns `(data_ddr & data_port) | (~data_ddr & sync)`.
  - FLAG, MASK and POL return their register contents.
- **Interrupt:** `irq_n` is registered from `~|(flag_next & mask_next)`.
- **Simultaneous strobes:** if `re` and `we` are both high, the write takes effect and the read returns the pre-write value.
- **Output-mode bits:** DDR=1 bits never set flags. Flags that are already set persist across DDR changes until cleared.

## Timing
- **Reset values:**
  - `data_out` = 0x00.
  - `irq_n` = 1.
  - FLAG = MASK = POL = 0x00.
  - All sync stages and `prev` = 0xFF, matching the idle-high port. This means no spurious edge on reset release.
- **Read latency:** `data_out` is valid one cycle after the `re` cycle.
- **Pin-to-flag latency:**
  - A pin change meeting setup at edge N appears on `sync` after edge N+SYNC_STAGES−1.
  - The flag sets at edge N+SYNC_STAGES.
  - `irq_n` falls at the same edge when the bit is masked in.
- **Clear-to-irq latency:** a clear or mask write at edge M deasserts `irq_n` at edge M.
- **Pulse width:** pulses shorter than one clock may be missed. A sustained level change produces exactly one flag set.
- **Reset mid-operation:** all state returns to reset values immediately, with no dependence on the clock.

## Configuration
- Macro: `IOPORT_READER_GLITCH_FILTER_EN`.
- **Defined:**
  - A 3-sample agreement filter sits after the synchroniser.
  - The filtered value updates only when three consecutive `sync` samples agree, otherwise it holds.
  - Edge detection and PIN reads use the filtered value.
  - Pin-to-flag latency grows by 2 cycles.
  - Single-cycle glitches generate no flag.
  - Filter reset value is 0xFF.
- **Undefined:** no filter; the raw `sync` value drives edge detection and PIN reads.

## Structure
- **Package `ioport_reader_pkg`:**
  - Address constants `ADDR_PIN`, `ADDR_FLAG`, `ADDR_MASK`, `ADDR_POL`.
  - `PIN_IDLE` = 8'hFF.
  - `SYNC_STAGES` bounds.
- **Sub-module `pin_sync`:**
  - Per-bit synchroniser, optional filter, `prev` flop and rise/fall outputs.
  - Instantiated 8 times via generate.
  - The top level holds the registers, flag logic and read mux.

## Test plan
- **Reset idle:** reset with `pins`=0xFF, then release. Required response: FLAG=0x00, `irq_n`=1, PIN read returns 0xFF.
- **Falling-edge interrupt:** DDR=0x00, POL=0x00, MASK=0x01, drive pin0 1→0. Required response: FLAG bit0 sets SYNC_STAGES edges later and `irq_n` goes low at that same edge.
- **Mixed-direction read:** DDR=0xF0, `data_port`=0xA5, `pins`=0x3C. Required response: PIN read returns 0xAC.
- **Set beats clear:** FLAG=0x02 and MASK=0x02; in the same cycle, write FLAG with 0x02 (W1C) while bit1 gets a new edge. Required response: FLAG stays 0x02 and `irq_n` stays low.
- **Read-to-clear:** read FLAG=0x81 → `data_out`=0x81, FLAG becomes 0x00. An edge on bit3 landing in the read cycle must survive (FLAG=0x08).
- **Glitch filter (macro defined):** one-cycle low pulse on pin2 → no flag set. Three-cycle low pulse → FLAG bit2 sets at latency SYNC_STAGES+2.
